// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - stage-0 fetch sequencer: program counter, fetch tagging, redirect squash, halt.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise fetch_misaligned.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        halt_req,
   output logic [31:0] long_instruction_addr,
   output logic        is_instr_stage,
   output logic [31:0] fetch_pc,
   output logic        fetch_valid,
   output logic        halted,
   output logic        fetch_misaligned
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [31:0] STEP = 32'(PC_STEP);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic        misaligned_q, misaligned_d;
   logic        redirect_bad;
   logic [31:0] redirect_pc;

   // Targets are always loaded word aligned; the low bits only matter to the optional check.
   assign redirect_pc = redirect_target & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
   assign redirect_bad = (redirect_target[1:0] != 2'b00);
`else
   assign redirect_bad = 1'b0;
`endif

   assign is_instr_stage = (state_q == ST_RUN) && !stall && !halt_req && !reset;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_pc_d    = fetch_pc_q;
      fetch_valid_d = 1'b0;
      misaligned_d  = misaligned_q;

      if (is_instr_stage) begin
         fetch_pc_d = pc_q;
      end

      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (halt_req) begin
               state_d = ST_HALT;
            end else if (redirect_valid) begin
               // The word fetched this cycle is on the wrong path, so it is squashed.
               if (redirect_bad) begin
                  misaligned_d = 1'b1;
                  state_d      = ST_HALT;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (is_instr_stage) begin
               pc_d          = pc_q + STEP;
               fetch_valid_d = 1'b1;
            end else begin
               fetch_valid_d = fetch_valid_q;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         fetch_pc_q    <= RESET_PC;
         fetch_valid_q <= 1'b0;
         misaligned_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_pc_q    <= fetch_pc_d;
         fetch_valid_q <= fetch_valid_d;
         misaligned_q  <= misaligned_d;
      end
   end

   assign long_instruction_addr = pc_q;
   assign fetch_pc              = fetch_pc_q;
   assign fetch_valid           = fetch_valid_q;
   assign halted                = (state_q == ST_HALT);
   assign fetch_misaligned      = misaligned_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit.
module tb_fetch_pc_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halt_req;
   logic [31:0] long_instruction_addr;
   logic        is_instr_stage;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        halted;
   logic        fetch_misaligned;

   int n_checks = 0;
   int n_pass   = 0;

   fetch_pc_unit #(
      .RESET_PC(32'h0000_0000),
      .PC_STEP (4)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .stall                (stall),
      .redirect_valid       (redirect_valid),
      .redirect_target      (redirect_target),
      .halt_req             (halt_req),
      .long_instruction_addr(long_instruction_addr),
      .is_instr_stage       (is_instr_stage),
      .fetch_pc             (fetch_pc),
      .fetch_valid          (fetch_valid),
      .halted               (halted),
      .fetch_misaligned     (fetch_misaligned)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Checks the full observable state after inputs have settled.
   task automatic expect_all(input string tag, input logic [31:0] addr, input logic ise,
                             input logic [31:0] fpc, input logic fv, input logic hl);
      #1;
      check({tag, ".addr"}, long_instruction_addr, addr);
      check({tag, ".ise"}, 32'(is_instr_stage), 32'(ise));
      check({tag, ".fpc"}, fetch_pc, fpc);
      check({tag, ".fv"}, 32'(fetch_valid), 32'(fv));
      check({tag, ".halted"}, 32'(halted), 32'(hl));
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
      redirect_target = 32'h0; halt_req = 1'b0;
      step(); step();
      expect_all("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("reset.misaligned", 32'(fetch_misaligned), 32'h0);

      reset = 1'b0;
      expect_all("boot", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      expect_all("run0", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step();
         expect_all("seq", 32'(4 * i), 1'b1, 32'(4 * (i - 1)), 1'b1, 1'b0);
      end

      // pc = 0x10, stall for three cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         expect_all("stall", 32'h10, 1'b0, 32'h0C, 1'b1, 1'b0);
         step();
      end
      stall = 1'b0;
      expect_all("resume", 32'h10, 1'b1, 32'h0C, 1'b1, 1'b0);
      step();
      expect_all("resume1", 32'h14, 1'b1, 32'h10, 1'b1, 1'b0);
      step(); step(); step();
      expect_all("at20", 32'h20, 1'b1, 32'h1C, 1'b1, 1'b0);

      redirect_valid = 1'b1; redirect_target = 32'h100;
      step();
      redirect_valid = 1'b0;
      expect_all("redir1", 32'h100, 1'b1, 32'h20, 1'b0, 1'b0);
      step();
      expect_all("redir2", 32'h104, 1'b1, 32'h100, 1'b1, 1'b0);

      stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
      step();
      redirect_valid = 1'b0;
      expect_all("rdst1", 32'h40, 1'b0, 32'h100, 1'b0, 1'b0);
      step();
      stall = 1'b0;
      expect_all("rdst2", 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      step();
      expect_all("rdst3", 32'h44, 1'b1, 32'h40, 1'b1, 1'b0);

      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      expect_all("wrap0", 32'hFFFF_FFFC, 1'b1, 32'h44, 1'b0, 1'b0);
      step();
      expect_all("wrap1", 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);

      redirect_valid = 1'b1; redirect_target = 32'h102;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      expect_all("misal", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("misal.flag", 32'(fetch_misaligned), 32'h1);
`else
      expect_all("misal", 32'h100, 1'b1, 32'h0, 1'b0, 1'b0);
      check("misal.flag", 32'(fetch_misaligned), 32'h0);
`endif

      // Mid-operation reset, then redirects in BOOT must be ignored.
      reset = 1'b1;
      #1 check("rst.ise", 32'(is_instr_stage), 32'h0);
      step();
      reset = 1'b0;
      redirect_valid = 1'b1; redirect_target = 32'h200;
      expect_all("boot2", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("boot2.misaligned", 32'(fetch_misaligned), 32'h0);
      step();
      redirect_target = 32'h30;
      expect_all("bootign", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      step();
      redirect_valid = 1'b0;
      expect_all("at30", 32'h30, 1'b1, 32'h0, 1'b0, 1'b0);

      halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
      #1 check("halt.ise", 32'(is_instr_stage), 32'h0);
      step();
      halt_req = 1'b0; redirect_target = 32'h500;
      for (int i = 0; i < 20; i++) begin
         stall = i[0];
         #1;
         check("hold.ise", 32'(is_instr_stage), 32'h0);
         check("hold.addr", long_instruction_addr, 32'h30);
         check("hold.halted", 32'(halted), 32'h1);
         check("hold.fv", 32'(fetch_valid), 32'h0);
         step();
      end
      redirect_valid = 1'b0; stall = 1'b0;

      reset = 1'b1;
      step();
      reset = 1'b0;
      expect_all("rehalt", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      expect_all("rerun", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
